// File: rtl/jt900h_bus_arb_pkg.sv
// Shared types for the JT900H RAM bus arbiter.
// State and owner codes plus bus widths.
package jt900h_bus_arb_pkg;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int CW = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [1:0]    we;
  } acc_t;

endpackage

// File: rtl/jt900h_bus_arb_if.sv
// Requester, external-master and RAM pins of the bus arbiter.
// slave = arbiter side, master = requester/RAM side.
interface jt900h_bus_arb_if;
  import jt900h_bus_arb_pkg::*;

  logic          cpu_req;
  logic          cpu_lock;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic [1:0]    cpu_we;
  logic          cpu_ack;
  logic [DW-1:0] cpu_dout;

  logic          dma_req;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_din;
  logic [1:0]    dma_we;
  logic          dma_ack;
  logic [DW-1:0] dma_dout;

  logic          busrq;
  logic          busak;

  logic          ram_cs;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [1:0]    ram_we;
  logic [DW-1:0] ram_dout;

  modport slave (
    input  cpu_req, cpu_lock, cpu_addr,
    input  cpu_din, cpu_we,
    output cpu_ack, cpu_dout,
    input  dma_req, dma_addr,
    input  dma_din, dma_we,
    output dma_ack, dma_dout,
    input  busrq,
    output busak,
    output ram_cs, ram_addr, ram_din, ram_we,
    input  ram_dout
  );

  modport master (
    output cpu_req, cpu_lock, cpu_addr,
    output cpu_din, cpu_we,
    input  cpu_ack, cpu_dout,
    output dma_req, dma_addr,
    output dma_din, dma_we,
    input  dma_ack, dma_dout,
    output busrq,
    input  busak,
    input  ram_cs, ram_addr, ram_din, ram_we,
    output ram_dout
  );

endinterface

// File: rtl/jt900h_bus_arb_wait.sv
// Wait-state counter: loadable down-counter with zero flag.
// Advances only on cen; stops at zero.
module jt900h_bus_wait
  import jt900h_bus_arb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          load,
  input  logic [CW-1:0] val,
  output logic          zero
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cen) begin
      if (load)
        cnt <= val;
      else if (cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/jt900h_bus_arb.sv
// RAM bus arbiter: CPU vs micro-DMA, wait states,
// and bus release to an external master.
module jt900h_bus_arb
  import jt900h_bus_arb_pkg::*;
#(
  parameter int WAIT   = 0,
  parameter int STARVE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  jt900h_bus_arb_if.slave bus
);

  localparam logic [3:0] SMAX = 4'(STARVE);

  state_t     st, st_nx;
  owner_t     owner;
  logic [3:0] starve;
  logic       cpu_c, dma_c;
  logic       gnt_cpu, gnt_dma;
  logic       go_halt, done, zero;
  acc_t       cpu_a, dma_a, win;

  assign cpu_a = {bus.cpu_addr, bus.cpu_din, bus.cpu_we};
  assign dma_a = {bus.dma_addr, bus.dma_din, bus.dma_we};
  assign win   = gnt_dma ? dma_a : cpu_a;

  // A requester still showing its ack gets one period to drop req
  assign cpu_c = bus.cpu_req & ~bus.cpu_ack;
  assign dma_c = bus.dma_req & ~bus.dma_ack;

  jt900h_bus_wait u_wait (
    .clk  (clk),
    .rst  (rst),
    .cen  (cen),
    .load (gnt_cpu | gnt_dma),
    .val  (CW'(WAIT)),
    .zero (zero)
  );

  always_ff @(posedge clk) begin
    if (rst)
      st <= IDLE;
    else if (cen)
      st <= st_nx;
  end

  always_comb begin
    st_nx   = st;
    gnt_cpu = 1'b0;
    gnt_dma = 1'b0;
    go_halt = 1'b0;
    done    = 1'b0;
    unique case (st)
      IDLE: begin
        if (cpu_c && owner == OWN_CPU && bus.cpu_lock)
          gnt_cpu = 1'b1;
        else if (bus.busrq)
          go_halt = 1'b1;
        else if (cpu_c && starve == SMAX)
          gnt_cpu = 1'b1;
        else if (dma_c)
          gnt_dma = 1'b1;
        else if (cpu_c)
          gnt_cpu = 1'b1;
        if (gnt_cpu || gnt_dma)
          st_nx = ACC;
        else if (go_halt)
          st_nx = HALT;
      end
      ACC: begin
        if (zero) begin
          done  = 1'b1;
          st_nx = IDLE;
        end
      end
      HALT: begin
        if (!bus.busrq)
          st_nx = IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner        <= OWN_CPU;
      starve       <= '0;
      bus.cpu_ack  <= 1'b0;
      bus.cpu_dout <= '0;
      bus.dma_ack  <= 1'b0;
      bus.dma_dout <= '0;
      bus.busak    <= 1'b0;
      bus.ram_cs   <= 1'b0;
      bus.ram_addr <= '0;
      bus.ram_din  <= '0;
      bus.ram_we   <= '0;
    end else if (cen) begin
      bus.cpu_ack <= 1'b0;
      bus.dma_ack <= 1'b0;
      if (gnt_cpu || gnt_dma) begin
        owner        <= gnt_dma ? OWN_DMA : OWN_CPU;
        bus.ram_cs   <= 1'b1;
        bus.ram_addr <= win.addr;
        bus.ram_din  <= win.din;
        bus.ram_we   <= win.we;
      end
      if (go_halt) begin
        bus.busak    <= 1'b1;
        bus.ram_cs   <= 1'b0;
        bus.ram_addr <= '0;
        bus.ram_din  <= '0;
        bus.ram_we   <= '0;
      end
      if (st == HALT && !bus.busrq)
        bus.busak <= 1'b0;
      if (done) begin
        bus.ram_cs <= 1'b0;
        bus.ram_we <= '0;
        if (owner == OWN_DMA) begin
          bus.dma_dout <= bus.ram_dout;
          bus.dma_ack  <= 1'b1;
        end else begin
          bus.cpu_dout <= bus.ram_dout;
          bus.cpu_ack  <= 1'b1;
        end
      end
      if (!bus.cpu_req || gnt_cpu)
        starve <= '0;
      else if (gnt_dma && starve != SMAX)
        starve <= starve + 1'b1;
    end
  end

endmodule

// File: tb/tb_jt900h_bus_arb.sv
// Directed bench for jt900h_bus_arb: vector table
// plus arbitration / wait-state / reset sequences.
module tb_jt900h_bus_arb;

  logic clk;
  logic rst;
  logic cen;

  jt900h_bus_arb_if b0 ();
  jt900h_bus_arb_if b3 ();

  jt900h_bus_arb #(.WAIT(0), .STARVE(4)) u0 (
    .clk (clk),
    .rst (rst),
    .cen (cen),
    .bus (b0)
  );

  jt900h_bus_arb #(.WAIT(3), .STARVE(4)) u3 (
    .clk (clk),
    .rst (rst),
    .cen (cen),
    .bus (b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic cpu_drop = 1'b0;
  logic dma_drop = 1'b0;

  localparam byte GC = 8'h43;
  localparam byte GD = 8'h44;
  byte glog[$];

  // grant log for b0 (WAIT=0: ram_cs is high one sample per grant)
  always @(posedge clk) begin
    #1;
    if (b0.ram_cs === 1'b1)
      glog.push_back(b0.ram_addr[23:20] == 4'hD ? GD : GC);
  end

  typedef struct {
    logic        dma;
    logic [23:0] addr;
    logic [15:0] din;
    logic [1:0]  we;
    logic [15:0] rd;
    logic [23:0] e_addr;
    logic [15:0] e_din;
    logic [1:0]  e_we;
    logic [15:0] e_dout;
  } vec_t;

  vec_t tv[5];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(int n);
    repeat (n) begin
      step();
      if (cpu_drop && b0.cpu_ack) b0.cpu_req = 1'b0;
      if (dma_drop && b0.dma_ack) b0.dma_req = 1'b0;
    end
  endtask

  task automatic chk_log(string name, byte e[]);
    chk({name, "_n"}, glog.size(), e.size());
    foreach (e[i])
      chk($sformatf("%s_%0d", name, i),
          glog.size() > i ? glog[i] : 8'h00, e[i]);
  endtask

  initial begin
    tv[0] = '{1'b0, 24'h001234, 16'h0000, 2'b00, 16'hBEEF,
              24'h001234, 16'h0000, 2'b00, 16'hBEEF};
    tv[1] = '{1'b0, 24'h7FFFFE, 16'hA55A, 2'b11, 16'h1111,
              24'h7FFFFE, 16'hA55A, 2'b11, 16'h1111};
    tv[2] = '{1'b1, 24'h200010, 16'h00FF, 2'b10, 16'h2222,
              24'h200010, 16'h00FF, 2'b10, 16'h2222};
    tv[3] = '{1'b1, 24'hFFFFFF, 16'h1234, 2'b00, 16'hC0DE,
              24'hFFFFFF, 16'h1234, 2'b00, 16'hC0DE};
    tv[4] = '{1'b0, 24'h000001, 16'hFFFF, 2'b01, 16'h8001,
              24'h000001, 16'hFFFF, 2'b01, 16'h8001};

    rst = 1'b1;
    cen = 1'b1;
    {b0.cpu_req, b0.cpu_lock, b0.cpu_addr, b0.cpu_din, b0.cpu_we} = '0;
    {b0.dma_req, b0.dma_addr, b0.dma_din, b0.dma_we} = '0;
    {b0.busrq, b0.ram_dout} = '0;
    {b3.cpu_req, b3.cpu_lock, b3.cpu_addr, b3.cpu_din, b3.cpu_we} = '0;
    {b3.dma_req, b3.dma_addr, b3.dma_din, b3.dma_we} = '0;
    {b3.busrq, b3.ram_dout} = '0;
    step();
    step();
    chk("rst_cs", b0.ram_cs, 0);
    chk("rst_busak", b0.busak, 0);
    chk("rst_cpu_ack", b0.cpu_ack, 0);
    chk("rst_dma_ack", b0.dma_ack, 0);
    chk("rst_addr", b0.ram_addr, 0);
    chk("rst_cpu_dout", b0.cpu_dout, 0);
    rst = 1'b0;
    step();

    // single accesses, WAIT=0
    for (int i = 0; i < 5; i++) begin
      if (tv[i].dma) begin
        b0.dma_req  = 1'b1;
        b0.dma_addr = tv[i].addr;
        b0.dma_din  = tv[i].din;
        b0.dma_we   = tv[i].we;
      end else begin
        b0.cpu_req  = 1'b1;
        b0.cpu_addr = tv[i].addr;
        b0.cpu_din  = tv[i].din;
        b0.cpu_we   = tv[i].we;
      end
      b0.ram_dout = 16'h5555;
      step();
      chk($sformatf("v%0d_cs", i), b0.ram_cs, 1);
      chk($sformatf("v%0d_addr", i), b0.ram_addr, tv[i].e_addr);
      chk($sformatf("v%0d_din", i), b0.ram_din, tv[i].e_din);
      chk($sformatf("v%0d_we", i), b0.ram_we, tv[i].e_we);
      b0.ram_dout = tv[i].rd;
      step();
      chk($sformatf("v%0d_ack", i),
          tv[i].dma ? b0.dma_ack : b0.cpu_ack, 1);
      chk($sformatf("v%0d_oack", i),
          tv[i].dma ? b0.cpu_ack : b0.dma_ack, 0);
      chk($sformatf("v%0d_dout", i),
          tv[i].dma ? b0.dma_dout : b0.cpu_dout, tv[i].e_dout);
      chk($sformatf("v%0d_cs0", i), b0.ram_cs, 0);
      chk($sformatf("v%0d_we0", i), b0.ram_we, 0);
      b0.cpu_req = 1'b0;
      b0.dma_req = 1'b0;
      step();
      chk($sformatf("v%0d_ackw", i),
          tv[i].dma ? b0.dma_ack : b0.cpu_ack, 0);
    end

    // cen=0 freezes both the access and the ack width
    b0.cpu_req  = 1'b1;
    b0.cpu_addr = 24'h000100;
    b0.cpu_we   = 2'b00;
    b0.ram_dout = 16'h0F0F;
    step();
    cen = 1'b0;
    step();
    step();
    chk("cen_hold_cs", b0.ram_cs, 1);
    chk("cen_hold_ack", b0.cpu_ack, 0);
    cen = 1'b1;
    step();
    chk("cen_ack", b0.cpu_ack, 1);
    chk("cen_dout", b0.cpu_dout, 16'h0F0F);
    b0.cpu_req = 1'b0;
    cen = 1'b0;
    step();
    step();
    chk("cen_ack_hold", b0.cpu_ack, 1);
    cen = 1'b1;
    step();
    chk("cen_ack_end", b0.cpu_ack, 0);

    // simultaneous requests: DMA first, then CPU
    b0.cpu_addr = 24'hC00010;
    b0.cpu_din  = 16'h1111;
    b0.dma_addr = 24'hD00020;
    b0.dma_we   = 2'b00;
    glog.delete();
    cpu_drop = 1'b1;
    dma_drop = 1'b1;
    b0.cpu_req = 1'b1;
    b0.dma_req = 1'b1;
    run(8);
    chk_log("t2", '{GD, GC});

    // starvation: busrq steals the post-ack slot so DMA wins 4 in a row
    cpu_drop = 1'b0;
    dma_drop = 1'b0;
    glog.delete();
    b0.cpu_req = 1'b1;
    b0.dma_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      b0.busrq = 1'b1;
      step();
      step();
      chk($sformatf("t3_busak%0d", k), b0.busak, 1);
      chk($sformatf("t3_hcs%0d", k), b0.ram_cs, 0);
      b0.busrq = 1'b0;
      step();
      chk($sformatf("t3_rel%0d", k), b0.busak, 0);
    end
    step();
    chk("t3_force", b0.ram_addr, 24'hC00010);
    cpu_drop = 1'b1;
    dma_drop = 1'b1;
    run(8);
    chk_log("t3", '{GD, GD, GD, GD, GC, GD});
    cpu_drop = 1'b0;
    dma_drop = 1'b0;

    // lock: CPU regranted over busrq and DMA
    b0.cpu_req  = 1'b1;
    b0.cpu_lock = 1'b1;
    step();
    chk("t4_g1", b0.ram_addr, 24'hC00010);
    step();
    chk("t4_ack1", b0.cpu_ack, 1);
    step();
    chk("t4_gap", b0.ram_cs, 0);
    b0.busrq   = 1'b1;
    b0.dma_req = 1'b1;
    step();
    chk("t4_g2cs", b0.ram_cs, 1);
    chk("t4_g2", b0.ram_addr, 24'hC00010);
    chk("t4_nobusak", b0.busak, 0);
    b0.cpu_lock = 1'b0;
    step();
    chk("t4_ack2", b0.cpu_ack, 1);
    chk("t4_nobusak2", b0.busak, 0);
    b0.cpu_req = 1'b0;
    step();
    chk("t4_busak", b0.busak, 1);
    chk("t6_cs", b0.ram_cs, 0);
    chk("t6_addr", b0.ram_addr, 0);
    chk("t6_din", b0.ram_din, 0);
    chk("t6_we", b0.ram_we, 0);
    b0.busrq = 1'b0;
    step();
    chk("t6_rel", b0.busak, 0);
    chk("t6_nogrant", b0.ram_cs, 0);
    step();
    chk("t6_dma_cs", b0.ram_cs, 1);
    chk("t6_dma_addr", b0.ram_addr, 24'hD00020);
    step();
    chk("t6_dma_ack", b0.dma_ack, 1);
    b0.dma_req = 1'b0;
    step();

    // WAIT=3: four stable samples, ack after the fifth edge
    b3.cpu_req  = 1'b1;
    b3.cpu_addr = 24'h00ABCD;
    b3.cpu_din  = 16'h5A5A;
    b3.cpu_we   = 2'b11;
    b3.ram_dout = 16'h1357;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("t5_cs%0d", k), b3.ram_cs, 1);
      chk($sformatf("t5_addr%0d", k), b3.ram_addr, 24'h00ABCD);
      chk($sformatf("t5_we%0d", k), b3.ram_we, 2'b11);
      chk($sformatf("t5_noack%0d", k), b3.cpu_ack, 0);
    end
    step();
    chk("t5_ack", b3.cpu_ack, 1);
    chk("t5_dout", b3.cpu_dout, 16'h1357);
    chk("t5_cs0", b3.ram_cs, 0);
    b3.cpu_req = 1'b0;
    step();
    chk("t5_ack0", b3.cpu_ack, 0);

    // reset in the middle of a wait-stated access
    b3.cpu_req = 1'b1;
    step();
    step();
    chk("t5r_busy", b3.ram_cs, 1);
    rst = 1'b1;
    step();
    chk("t5r_cs", b3.ram_cs, 0);
    chk("t5r_addr", b3.ram_addr, 0);
    chk("t5r_din", b3.ram_din, 0);
    chk("t5r_we", b3.ram_we, 0);
    chk("t5r_ack", b3.cpu_ack, 0);
    chk("t5r_dout", b3.cpu_dout, 0);
    chk("t5r_busak", b3.busak, 0);
    b3.cpu_req = 1'b0;
    rst = 1'b0;
    repeat (5) begin
      step();
      chk("t5r_noack", b3.cpu_ack, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
